// File: rtl/pim_pkg.sv
// pim_pkg: shared types and sizing helpers for the PIM tile scheduler.
//   pim_job_t     - job payload held by each slot (ti, tj, tk, first, last)
//   slot_state_e  - per-unit slot FSM states
//   sched_state_e - top-level scheduler FSM states
//   idx_w / sz_w  - width helpers for tile indices and the size port
package pim_pkg;

    // Payload fields are stored at a fixed width wide enough for any
    // practical tile count; the top narrows them to IDX_W at its ports.
    localparam int JOB_W = 8;

    typedef struct packed {
        logic [JOB_W-1:0] ti;
        logic [JOB_W-1:0] tj;
        logic [JOB_W-1:0] tk;
        logic             first;
        logic             last;
    } pim_job_t;

    typedef enum logic [1:0] {FREE, OFFER, WAIT} slot_state_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_e;

    function automatic int idx_w(input int nt);
        return (nt <= 2) ? 1 : $clog2(nt);
    endfunction

    function automatic int sz_w(input int max_size);
        return $clog2(max_size + 1);
    endfunction

endpackage

// File: rtl/pim_sched_slot.sv
// pim_sched_slot: one job slot bound to a single PIM unit.
// Takes an output tile, offers its k-sequence (tk = 0..T-1) one job at a
// time, waiting for the unit's pim_done between jobs.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   take_i            parent grants the next tile to this slot
//   ti_i, tj_i        granted tile coordinates
//   tlast_i           T-1 for the current run
//   job_ready_i       unit accepts the offered job
//   pim_done_i        unit finished its accepted job
//   avail_o           slot can take a tile this cycle (free or finishing)
//   job_valid_o       job offer
//   job_o             held job payload
module pim_sched_slot
    import pim_pkg::*;
#(
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             take_i,
    input  logic [IDX_W-1:0] ti_i,
    input  logic [IDX_W-1:0] tj_i,
    input  logic [IDX_W-1:0] tlast_i,
    input  logic             job_ready_i,
    input  logic             pim_done_i,
    output logic             avail_o,
    output logic             job_valid_o,
    output pim_job_t         job_o
);

    slot_state_e      state_q;
    pim_job_t         job_q;
    pim_job_t         new_job;
    logic [JOB_W-1:0] tk_nxt;

    assign new_job = '{ti: JOB_W'(ti_i), tj: JOB_W'(tj_i), tk: '0,
                       first: 1'b1, last: (tlast_i == '0)};
    assign tk_nxt  = job_q.tk + JOB_W'(1);

    // A slot whose final k job completes this cycle can be handed a new
    // tile immediately, so the next offer appears without a FREE bubble.
    assign avail_o     = (state_q == FREE) ||
                         ((state_q == WAIT) && pim_done_i && job_q.last);
    assign job_valid_o = (state_q == OFFER);
    assign job_o       = job_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
            job_q   <= '0;
        end else begin
            case (state_q)
                FREE: begin
                    if (take_i) begin
                        state_q <= OFFER;
                        job_q   <= new_job;
                    end
                end
                OFFER: begin
                    if (job_ready_i) state_q <= WAIT;
                end
                WAIT: begin
                    if (pim_done_i) begin
                        if (!job_q.last) begin
                            state_q     <= OFFER;
                            job_q.tk    <= tk_nxt;
                            job_q.first <= 1'b0;
                            job_q.last  <= (tk_nxt == JOB_W'(tlast_i));
                        end else if (take_i) begin
                            state_q <= OFFER;
                            job_q   <= new_job;
                        end else begin
                            state_q <= FREE;
                        end
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

endmodule

// File: rtl/pim_tile_scheduler.sv
// pim_tile_scheduler: splits C = A*B into TILE x TILE output tiles and binds
// each tile to one free PIM unit, which then receives the whole k-sequence.
// Optional feature macro: PIM_SCHED_PERF_EN (adds perf_cycles / perf_jobs).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, size              command strobe and matrix dimension
//   busy, done, err          run status; err accompanies done on bad size
//   job_valid / job_ready    per-unit job handshake
//   job_ti/tj/tk             per-unit job payload
//   job_first / job_last     accumulator clear / tile writeback markers
//   pim_done                 per-unit job completion pulse
//   perf_cycles, perf_jobs   busy cycles and handshakes (PIM_SCHED_PERF_EN)
module pim_tile_scheduler
    import pim_pkg::*;
#(
    parameter  int NUM_PIM  = 4,
    parameter  int MAX_SIZE = 16,
    parameter  int TILE     = 8,
    localparam int NT       = MAX_SIZE / TILE,
    localparam int IDX_W    = idx_w(NT),
    localparam int SZ_W     = sz_w(MAX_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SZ_W-1:0]                 size,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [NUM_PIM-1:0]              job_valid,
    input  logic [NUM_PIM-1:0]              job_ready,
    output logic [NUM_PIM-1:0][IDX_W-1:0]   job_ti,
    output logic [NUM_PIM-1:0][IDX_W-1:0]   job_tj,
    output logic [NUM_PIM-1:0][IDX_W-1:0]   job_tk,
    output logic [NUM_PIM-1:0]              job_first,
    output logic [NUM_PIM-1:0]              job_last,
    input  logic [NUM_PIM-1:0]              pim_done
`ifdef PIM_SCHED_PERF_EN
    ,
    output logic [31:0]                     perf_cycles,
    output logic [31:0]                     perf_jobs
`endif
);

    localparam int CNT_W = $clog2(NT * NT + 1);

    sched_state_e             state_q;
    logic                     busy_q, done_q, err_q;
    logic [IDX_W-1:0]         tlast_q, ti_q, tj_q;
    logic [CNT_W-1:0]         rem_q;

    logic                     legal, launch, run_act, fin;
    logic [SZ_W:0]            size_up;
    logic [IDX_W-1:0]         tlast_new, tlast;
    logic [CNT_W-1:0]         tiles_new;
    logic [IDX_W-1:0]         ti_c, tj_c;
    logic [CNT_W-1:0]         rem_c;
    logic [NUM_PIM-1:0]       take, avail;
    logic [NUM_PIM-1:0][IDX_W-1:0] tile_ti, tile_tj;
    pim_job_t [NUM_PIM-1:0]   job_w;

    assign legal     = (size != '0) && (int'(size) <= MAX_SIZE);
    assign size_up   = {1'b0, size} + (SZ_W+1)'(TILE - 1);
    assign tlast_new = IDX_W'(int'(size_up) / TILE - 1);
    assign tiles_new = CNT_W'((int'(tlast_new) + 1) * (int'(tlast_new) + 1));

    // Tile grant: walk units lowest index first, handing each available one
    // the next raster tile. On the accepting cycle the run parameters come
    // straight from the command so the first offers appear one cycle later.
    always_comb begin
        launch  = (state_q == IDLE) && start && legal;
        run_act = (state_q == RUN) || launch;
        tlast   = launch ? tlast_new : tlast_q;
        rem_c   = launch ? tiles_new : rem_q;
        ti_c    = launch ? '0 : ti_q;
        tj_c    = launch ? '0 : tj_q;
        take    = '0;
        tile_ti = '0;
        tile_tj = '0;
        for (int i = 0; i < NUM_PIM; i++) begin
            tile_ti[i] = ti_c;
            tile_tj[i] = tj_c;
            if (run_act && avail[i] && (rem_c != '0)) begin
                take[i] = 1'b1;
                rem_c   = rem_c - CNT_W'(1);
                if (tj_c == tlast) begin
                    tj_c = '0;
                    ti_c = ti_c + IDX_W'(1);
                end else begin
                    tj_c = tj_c + IDX_W'(1);
                end
            end
        end
    end

    // Nothing left to grant and every slot is (or becomes) free.
    assign fin = (state_q == RUN) && (rem_q == '0) && (&avail);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tlast_q <= '0;
            rem_q   <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
        end else begin
            if (run_act) begin
                rem_q <= rem_c;
                ti_q  <= ti_c;
                tj_q  <= tj_c;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            tlast_q <= tlast_new;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fin) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    for (genvar g = 0; g < NUM_PIM; g++) begin : g_slot
        pim_sched_slot #(.IDX_W(IDX_W)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .take_i      (take[g]),
            .ti_i        (tile_ti[g]),
            .tj_i        (tile_tj[g]),
            .tlast_i     (tlast),
            .job_ready_i (job_ready[g]),
            .pim_done_i  (pim_done[g]),
            .avail_o     (avail[g]),
            .job_valid_o (job_valid[g]),
            .job_o       (job_w[g])
        );
        assign job_ti[g]    = IDX_W'(job_w[g].ti);
        assign job_tj[g]    = IDX_W'(job_w[g].tj);
        assign job_tk[g]    = IDX_W'(job_w[g].tk);
        assign job_first[g] = job_w[g].first;
        assign job_last[g]  = job_w[g].last;
    end

`ifdef PIM_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_jobs_q, hs_cnt;
    logic [32:0] jobs_sum;

    always_comb begin
        hs_cnt = '0;
        for (int i = 0; i < NUM_PIM; i++)
            hs_cnt = hs_cnt + 32'(job_valid[i] & job_ready[i]);
        jobs_sum = {1'b0, perf_jobs_q} + {1'b0, hs_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            perf_cycles_q <= '0;
            perf_jobs_q   <= '0;
        end else begin
            if (busy_q && (perf_cycles_q != '1))
                perf_cycles_q <= perf_cycles_q + 32'd1;
            perf_jobs_q <= jobs_sum[32] ? '1 : jobs_sum[31:0];
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_jobs   = perf_jobs_q;
`endif

endmodule

// File: tb/tb_pim_tile_scheduler.sv
// Bench for pim_tile_scheduler: two instances (4 units and 2 units) share
// command stimulus; each has its own PIM unit emulator, a tile/queue model
// and a per-cycle compare process.
module tb_pim_tile_scheduler;

    localparam int MAXS = 16;
    localparam int TL   = 8;
    localparam int SZW  = 5;
    localparam int IW   = 1;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           start = 1'b0;
    logic [SZW-1:0] size  = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hold_until = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       busy_a, done_a, err_a, idle_a, payz_a;
    logic [1:0][3:0]  valid_a;
    logic [1:0][31:0] lat_a, mhs_a, dhs_a;

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int NP = (g == 0) ? 4 : 2;

        logic                   busy, done, err;
        logic [NP-1:0]          vld, rdy, pdone, first, last;
        logic [NP-1:0][IW-1:0]  ti, tj, tk;

        pim_tile_scheduler #(.NUM_PIM(NP), .MAX_SIZE(MAXS), .TILE(TL)) dut (
            .clk(clk), .rst(rst), .start(start), .size(size),
            .busy(busy), .done(done), .err(err),
            .job_valid(vld), .job_ready(rdy),
            .job_ti(ti), .job_tj(tj), .job_tk(tk),
            .job_first(first), .job_last(last), .pim_done(pdone)
        );

        // PIM unit emulator: accepts offers (unit 0 can be held off), then
        // pulses pim_done three cycles after each handshake.
        int cnt[NP];
        int dhs = 0;
        initial begin
            rdy   = '0;
            pdone = '0;
            for (int i = 0; i < NP; i++) cnt[i] = 0;
            forever begin
                @(negedge clk);
                #1;
                for (int i = 0; i < NP; i++) begin
                    pdone[i] = 1'b0;
                    if (rst) cnt[i] = 0;
                    else if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) pdone[i] = 1'b1;
                    end
                    rdy[i] = (i != 0) || (cyc >= hold_until);
                    if (!rst && vld[i] && rdy[i]) begin
                        cnt[i] = 3;
                        dhs++;
                    end
                end
            end
        end

        // Model: raster tile queue; each unit owns one tile and walks k.
        int mode = 0;           // 0 idle, 1 running, 2 done pulse
        int T = 1;
        int own[NP];
        int kk[NP];
        int ph[NP];             // 0 free, 1 offering, 2 working
        int q[$];
        int mhs = 0, t0 = 0, lat = 0;
        bit m_busy = 0, m_done = 0, m_err = 0;
        bit allfree;

        task automatic give();
            for (int i = 0; i < NP; i++)
                if (ph[i] == 0 && q.size() > 0) begin
                    own[i] = q.pop_front();
                    kk[i]  = 0;
                    ph[i]  = 1;
                end
        endtask

        always @(posedge clk) begin
            if (rst) begin
                mode = 0; m_busy = 0; m_done = 0; m_err = 0;
                q.delete();
                for (int i = 0; i < NP; i++) ph[i] = 0;
            end else if (mode == 0) begin
                if (start) begin
                    if (size >= 1 && int'(size) <= MAXS) begin
                        T = (int'(size) + TL - 1) / TL;
                        q.delete();
                        for (int a = 0; a < T * T; a++) q.push_back(a);
                        mode = 1; m_busy = 1; mhs = 0; t0 = cyc;
                        give();
                    end else begin
                        mode = 2; m_done = 1; m_err = 1;
                    end
                end
            end else if (mode == 1) begin
                allfree = 1;
                for (int i = 0; i < NP; i++) begin
                    if (ph[i] == 1 && rdy[i]) begin
                        ph[i] = 2;
                        mhs++;
                    end else if (ph[i] == 2 && pdone[i]) begin
                        if (kk[i] < T - 1) begin
                            kk[i]++;
                            ph[i] = 1;
                        end else ph[i] = 0;
                    end
                    if (ph[i] != 0) allfree = 0;
                end
                if (allfree && q.size() == 0) begin
                    mode = 2; m_busy = 0; m_done = 1; lat = cyc - t0;
                end else give();
            end else begin
                mode = 0; m_done = 0; m_err = 0;
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                tests++;
                if ({busy, done, err} !== {m_busy, m_done, m_err}) begin
                    fails++;
                    $display("FAIL ctl cfg%0d cyc%0d: busy/done/err got %b%b%b want %b%b%b",
                             g, cyc, busy, done, err, m_busy, m_done, m_err);
                end
                for (int i = 0; i < NP; i++) begin
                    tests++;
                    if (vld[i] !== (ph[i] == 1)) begin
                        fails++;
                        $display("FAIL valid cfg%0d u%0d cyc%0d: got %b want %b",
                                 g, i, cyc, vld[i], ph[i] == 1);
                    end else if (ph[i] == 1) begin
                        tests++;
                        if (int'(ti[i]) != own[i] / T || int'(tj[i]) != own[i] % T ||
                            int'(tk[i]) != kk[i] || first[i] !== (kk[i] == 0) ||
                            last[i] !== (kk[i] == T - 1)) begin
                            fails++;
                            $display("FAIL payload cfg%0d u%0d cyc%0d: got ti%0d tj%0d tk%0d f%b l%b want ti%0d tj%0d tk%0d",
                                     g, i, cyc, ti[i], tj[i], tk[i], first[i], last[i],
                                     own[i] / T, own[i] % T, kk[i]);
                        end
                    end
                end
            end
        end

        assign busy_a[g]  = busy;
        assign done_a[g]  = done;
        assign err_a[g]   = err;
        assign valid_a[g] = 4'(vld);
        assign payz_a[g]  = (ti == '0) && (tj == '0) && (tk == '0) &&
                            (first == '0) && (last == '0);
        assign idle_a[g]  = (mode == 0);
        assign lat_a[g]   = 32'(lat);
        assign mhs_a[g]   = 32'(mhs);
        assign dhs_a[g]   = 32'(dhs);
    end

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, int'(busy_a), 0);
        chk({nm, "_done"}, int'(done_a), 0);
        chk({nm, "_err"}, int'(err_a), 0);
        chk({nm, "_valid"}, int'(valid_a), 0);
        chk({nm, "_payload_zero"}, int'(payz_a), 3);
    endtask

    // One command; optional unit-0 ready hold and a stray start mid-run.
    task automatic run(input int s, input int hold, input bit poke,
                       output int h0, output int h1);
        int b0, b1;
        bit ok;
        b0 = int'(dhs_a[0]);
        b1 = int'(dhs_a[1]);
        @(negedge clk);
        start = 1'b1; size = SZW'(s); hold_until = cyc + 1 + hold;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (poke && n == 2) begin start = 1'b1; size = SZW'(8); end
            if (poke && n == 3) start = 1'b0;
            if (n > 3 && idle_a == 2'b11) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL run_timeout size%0d: got no done want done", s);
        end
        h0 = int'(dhs_a[0]) - b0;
        h1 = int'(dhs_a[1]) - b1;
    endtask

    int h0, h1;
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        chk_zero("reset");

        run(8, 0, 0, h0, h1);
        chk("s8_lat_cfg0", int'(lat_a[0]), 4);
        chk("s8_hs_model", int'(mhs_a[0]), 1);
        chk("s8_hs_dut0", h0, 1);
        chk("s8_hs_dut1", h1, 1);

        run(16, 0, 0, h0, h1);
        chk("s16_lat_cfg0", int'(lat_a[0]), 8);
        chk("s16_lat_cfg1", int'(lat_a[1]), 16);
        chk("s16_hs_dut0", h0, 8);
        chk("s16_hs_dut1", h1, 8);

        run(9, 0, 0, h0, h1);
        chk("s9_lat_cfg0", int'(lat_a[0]), 8);
        chk("s9_hs_model", int'(mhs_a[0]), 8);
        chk("s9_hs_dut0", h0, 8);
        chk("s9_hs_dut1", h1, 8);

        run(16, 5, 1, h0, h1);
        chk("hold_lat_cfg0", int'(lat_a[0]), 13);
        chk("hold_lat_cfg1", int'(lat_a[1]), 21);
        chk("hold_hs_dut0", h0, 8);
        chk("hold_hs_dut1", h1, 8);

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1; size = (k == 0) ? SZW'(0) : SZW'(17);
            @(negedge clk);
            start = 1'b0;
            chk("illegal_done", int'(done_a), 3);
            chk("illegal_err", int'(err_a), 3);
            chk("illegal_busy", int'(busy_a), 0);
            chk("illegal_valid", int'(valid_a), 0);
            @(negedge clk);
            chk("illegal_done_clr", int'(done_a), 0);
            chk("illegal_err_clr", int'(err_a), 0);
        end

        @(negedge clk);
        start = 1'b1; size = SZW'(16); hold_until = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midrun_rst");
        repeat (5) @(negedge clk);

        run(16, 0, 0, h0, h1);
        chk("after_rst_lat_cfg0", int'(lat_a[0]), 8);
        chk("after_rst_lat_cfg1", int'(lat_a[1]), 16);
        chk("after_rst_hs_dut0", h0, 8);
        chk("after_rst_hs_dut1", h1, 8);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pim_tile_scheduler.md
# pim_tile_scheduler

Parametrised tile-job scheduler for blocked matrix multiplication, C = A·B, across NUM_PIM processing-in-memory units. For a runtime matrix size it splits C into TILE×TILE output tiles, binds each output tile to one free PIM unit, and issues that unit the full k-sequence of tile jobs so accumulation stays local to the unit. It sits between the top-level command interface and the PIM unit array. It replaces fixed four-unit partitioning with correct k-accumulation, any unit count, backpressure and error reporting.

## Interface
- NUM_PIM, 4, number of PIM units (≥1)
- MAX_SIZE, 16, largest supported matrix dimension
- TILE, 8, tile edge; MAX_SIZE is a multiple of TILE
- Derived: NT = MAX_SIZE/TILE; IDX_W = max(1, $clog2(NT)); SZ_W = $clog2(MAX_SIZE+1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  command strobe, accepted only in IDLE
- size  in  SZ_W  matrix dimension, sampled with an accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  high with done when size was illegal
- job_valid  out  [NUM_PIM]  per-unit job offer
- job_ready  in  [NUM_PIM]  per-unit job acceptance
- job_ti, job_tj, job_tk  out  [NUM_PIM][IDX_W]  tile row, tile column, k index
- job_first  out  [NUM_PIM]  clear the accumulator before this job (tk==0)
- job_last  out  [NUM_PIM]  final k job; the unit writes back its tile after it
- pim_done  in  [NUM_PIM]  one-cycle pulse: the unit finished its accepted job

## Operation
- Top FSM: IDLE → RUN → DONE → IDLE. An illegal size goes IDLE → DONE directly, with err=1.
- Legal size: 1..MAX_SIZE. T = ceil(size/TILE), latched at start. There are T² output tiles, visited in raster order (ti outer, tj inner).
- Per-unit slot FSM: FREE → OFFER → WAIT → (OFFER with tk+1 | FREE).
  - FREE: if unassigned tiles remain, take the next tile and set tk=0.
  - OFFER: job_valid=1. Payload is held stable until job_valid && job_ready.
  - WAIT: wait for pim_done. If tk==T-1, the tile is complete; otherwise tk increments.
- Several free units in one cycle each take a tile, lowest index first, and the tile pointer advances by the number taken.
- job_first = (tk==0); job_last = (tk==T-1). Both are set together when T==1.
- RUN → DONE once all T² tiles are assigned and every slot is FREE.
- pim_done in FREE or OFFER is ignored. start outside IDLE is ignored.
- rst, including mid-RUN: all slots FREE, FSM IDLE, counters cleared, in-flight jobs abandoned.

## Timing
- All outputs reset to 0: busy, done, err, job_valid, job_ti/tj/tk, job_first, job_last.
- start accepted at cycle t: busy=1 and the first job_valid at t+1.
- Handshake completes at cycle h: the slot enters WAIT at h+1 with job_valid=0.
- pim_done at cycle d:
  - next job_valid for that unit at d+1 when more k remain or a new tile is taken;
  - when it is the final pim_done of the run, done=1 and busy=0 at d+1.
- Illegal size: done=err=1 at t+1 and busy never rises.
- err clears together with done.
- A new start is accepted in the cycle after done.

## Configuration
- PIM_SCHED_PERF_EN defined: adds outputs perf_cycles[31:0] and perf_jobs[31:0].
  - perf_cycles counts cycles with busy=1; perf_jobs counts completed handshakes.
  - Both clear on an accepted start and hold after done; saturating.
- Macro undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- pim_pkg holds:
  - pim_job_t struct {ti, tj, tk, first, last};
  - slot_state_e {FREE, OFFER, WAIT};
  - sched_state_e {IDLE, RUN, DONE};
  - the IDX_W/SZ_W helper functions.
- Sub-module pim_sched_slot: one per unit, generated NUM_PIM times. It owns the slot FSM, the tk counter and the held payload.
- The parent owns the top FSM, the tile pointer and the priority assignment.

## Test plan
- size=8, NUM_PIM=4: single job on unit 0 (ti=tj=tk=0, first=last=1). pim_done 3 cycles after acceptance → done 1 cycle later. Units 1-3 never valid.
- size=16, NUM_PIM=4: units 0..3 take tiles (0,0),(0,1),(1,0),(1,1), each getting tk=0 (first) then tk=1 (last). Exactly 8 handshakes, then done.
- size=9: T=2; same job set as size=16.
- size=16, NUM_PIM=2: units 0,1 take (0,0),(0,1), then (1,0),(1,1) after finishing. Total 8 jobs; done only after the fourth tile's last pim_done.
- job_ready[0] low for 5 cycles: job_valid[0] and payload held constant. Start of a second start while busy: ignored.
- size=0 and size=17: done=err=1 one cycle after start, no job_valid. Then rst mid-run at size=16: all outputs 0 next cycle, and a following start runs cleanly.
